// File: rtl/mrv1_pkg.sv
// Shared types for the data-memory responder: FSM state and error-cause encoding.
// Also provides the cause classifier used by the request address checker.
package mrv1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_NO_BE    = 2'd3
  } dmem_err_e;

  // Misalignment wins over range, range over an empty write mask.
  function automatic dmem_err_e classify_err(input logic misalign,
                                             input logic out_of_range,
                                             input logic no_be);
    if (misalign)          return ERR_MISALIGN;
    else if (out_of_range) return ERR_RANGE;
    else if (no_be)        return ERR_NO_BE;
    else                   return ERR_NONE;
  endfunction

endpackage

// File: rtl/mrv1_sram_1rw.sv
// Single-port word SRAM with byte-write enables and a registered read.
// One access per enabled cycle; read data appears the cycle after the access edge.
module mrv1_sram_1rw #(
  parameter int DEPTH_P = 1024,
  parameter int AW_P    = $clog2(DEPTH_P)
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [AW_P-1:0] addr_i,
  input  logic [31:0]     w_data_i,
  output logic [31:0]     r_data_o
);

  logic [3:0][7:0] mem [DEPTH_P];

  // Read-before-write: a write access returns the old word, which the caller discards.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i && be_i[b]) begin
          mem[addr_i][b] <= w_data_i[8*b +: 8];
        end
      end
      r_data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mrv1_dmem_resp.sv
// Data-memory responder: accepts one request in IDLE, waits WAIT_STATES_P cycles, pulses a response.
// Latency WAIT_STATES_P+1 cycles from accept; ready is held low until the response cycle has passed.
module mrv1_dmem_resp
  import mrv1_pkg::*;
#(
  parameter int          DATA_WIDTH_P  = 32,
  parameter int          DEPTH_P       = 1024,
  parameter logic [31:0] BASE_ADDR_P   = 32'h0000_0000,
  parameter int          WAIT_STATES_P = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dmem_req_vld_i,
  output logic                    dmem_req_rdy_o,
  input  logic [DATA_WIDTH_P-1:0] dmem_req_addr_i,
  input  logic                    dmem_req_w_en_i,
  input  logic [3:0]              dmem_req_w_be_i,
  input  logic [DATA_WIDTH_P-1:0] dmem_req_w_data_i,
  output logic                    dmem_resp_vld_o,
  output logic                    dmem_resp_err_o,
  output logic [DATA_WIDTH_P-1:0] dmem_resp_r_data_o
);

  localparam int                    AW        = $clog2(DEPTH_P);
  localparam logic [DATA_WIDTH_P-1:0] DEPTH_W  = DATA_WIDTH_P'(DEPTH_P);
  localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES_P - 1);

  dmem_state_e             state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH_P-1:0] addr_q, data_q;
  logic                    w_en_q, err_q;
  logic [3:0]              be_q;

  logic                    accept, access, use_live;
  logic [DATA_WIDTH_P-1:0] acc_addr, acc_data, idx;
  logic                    acc_w_en;
  logic [3:0]              acc_be;
  logic [DATA_WIDTH_P:0]   diff;
  dmem_err_e               cause;
  logic [31:0]             sram_r_data;

  assign dmem_req_rdy_o = (state_q == ST_IDLE) && !rst_i;
  assign accept         = dmem_req_vld_i && dmem_req_rdy_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES_P == 0) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the memory access happens on the accept edge, so use the live request.
  assign use_live = (state_q == ST_IDLE);
  assign acc_addr = use_live ? dmem_req_addr_i   : addr_q;
  assign acc_w_en = use_live ? dmem_req_w_en_i   : w_en_q;
  assign acc_be   = use_live ? dmem_req_w_be_i   : be_q;
  assign acc_data = use_live ? dmem_req_w_data_i : data_q;

  // One extra bit catches addresses below the base without wrapping.
  assign diff  = {1'b0, acc_addr} - {1'b0, BASE_ADDR_P};
  assign idx   = diff[DATA_WIDTH_P-1:0] >> 2;
  assign cause = classify_err(acc_addr[1:0] != 2'b00,
                              diff[DATA_WIDTH_P] || (idx >= DEPTH_W),
                              acc_w_en && (acc_be == 4'b0000));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= dmem_req_addr_i;
        w_en_q <= dmem_req_w_en_i;
        be_q   <= dmem_req_w_be_i;
        data_q <= dmem_req_w_data_i;
      end
      if (access) begin
        err_q <= (cause != ERR_NONE);
      end
    end
  end

  mrv1_sram_1rw #(
    .DEPTH_P (DEPTH_P),
    .AW_P    (AW)
  ) u_sram (
    .clk_i    (clk_i),
    .en_i     (access && !rst_i),
    .we_i     (acc_w_en && (cause == ERR_NONE)),
    .be_i     (acc_be),
    .addr_i   (idx[AW-1:0]),
    .w_data_i (acc_data),
    .r_data_o (sram_r_data)
  );

  assign dmem_resp_vld_o    = (state_q == ST_RESP) && !rst_i;
  assign dmem_resp_err_o    = dmem_resp_vld_o && err_q;
  assign dmem_resp_r_data_o = (dmem_resp_vld_o && !err_q && !w_en_q) ? sram_r_data : '0;

endmodule

// File: tb/tb_mrv1_dmem_resp.sv
// Bench for mrv1_dmem_resp: a 2-wait-state instance driven from a vector table and a
// 0-wait-state instance driven back-to-back; responses are matched against a scoreboard.
module tb_mrv1_dmem_resp;

  typedef struct {
    logic [31:0] addr;
    logic        w_en;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic        a_rst = 1'b1, a_vld = 1'b0, a_w_en = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_be = '0;
  logic        a_rdy, a_rvld, a_err;
  logic [31:0] a_rdata;

  logic        b_rst = 1'b1, b_vld = 1'b0, b_w_en = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_rdy, b_rvld, b_err;
  logic [31:0] b_rdata;

  mrv1_dmem_resp #(.WAIT_STATES_P(2)) dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .dmem_req_vld_i(a_vld), .dmem_req_rdy_o(a_rdy), .dmem_req_addr_i(a_addr),
    .dmem_req_w_en_i(a_w_en), .dmem_req_w_be_i(a_be), .dmem_req_w_data_i(a_wdata),
    .dmem_resp_vld_o(a_rvld), .dmem_resp_err_o(a_err), .dmem_resp_r_data_o(a_rdata)
  );

  mrv1_dmem_resp #(.WAIT_STATES_P(0)) dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .dmem_req_vld_i(b_vld), .dmem_req_rdy_o(b_rdy), .dmem_req_addr_i(b_addr),
    .dmem_req_w_en_i(b_w_en), .dmem_req_w_be_i(b_be), .dmem_req_w_data_i(b_wdata),
    .dmem_resp_vld_o(b_rvld), .dmem_resp_err_o(b_err), .dmem_resp_r_data_o(b_rdata)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic w_en, input logic [3:0] be,
                              input logic [31:0] data, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.addr = addr; v.w_en = w_en; v.be = be; v.data = data; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // Response monitors: every response must match the oldest expectation and arrive on its due cycle.
  always @(negedge clk) begin
    if (a_rvld) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_resp", 32'(a_rvld), 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_resp_err", 32'(a_err), 32'(ea.err));
        chk("a_resp_data", a_rdata, ea.data);
        chk("a_resp_cycle", cyc, ea.due);
      end
    end else begin
      chk("a_idle_outputs_zero", {a_err, a_rdata[30:0]} | {31'd0, a_rdata[31]}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (b_rvld) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_resp", 32'(b_rvld), 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_resp_err", 32'(b_err), 32'(eb.err));
        chk("b_resp_data", b_rdata, eb.data);
        chk("b_resp_cycle", cyc, eb.due);
      end
    end else begin
      chk("b_idle_outputs_zero", {b_err, b_rdata[30:0]} | {31'd0, b_rdata[31]}, 32'd0);
    end
  end

  task automatic send_a(input vec_t v, input bit expect_resp);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(posedge clk); #2;
    a_vld = 1'b1; a_addr = v.addr; a_w_en = v.w_en; a_be = v.be; a_wdata = v.data;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (a_rdy) begin
        if (expect_resp) begin
          e.err = v.err; e.data = v.rdata; e.due = cyc + 3;
          qa.push_back(e);
        end
        @(posedge clk); #2;
        a_vld = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("a_accept_timeout", 32'd0, 32'd1);
      a_vld = 1'b0;
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 50 && !empty; n++) begin
      @(negedge clk);
      empty = (qa.size() == 0) && (qb.size() == 0);
    end
    chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  vec_t vecs[16];
  vec_t bseq[4];

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   bi;

    vecs[0]  = mk(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    vecs[1]  = mk(32'h10, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(32'h10, 1'b1, 4'b0010, 32'h0000AA00, 1'b0, 32'h0);
    vecs[3]  = mk(32'h10, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF);
    vecs[4]  = mk(32'h13, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0);
    vecs[5]  = mk(32'h1000, 1'b0, 4'hF, 32'h0,      1'b1, 32'h0);
    vecs[6]  = mk(32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    vecs[7]  = mk(32'h10, 1'b0, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF);
    vecs[8]  = mk(32'h11, 1'b1, 4'hF, 32'h11111111, 1'b1, 32'h0);
    vecs[9]  = mk(32'h10, 1'b0, 4'h0, 32'h0,        1'b0, 32'hDEADAAEF);
    vecs[10] = mk(32'hFFC, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    vecs[11] = mk(32'hFFC, 1'b0, 4'hF, 32'h0,       1'b0, 32'hCAFEF00D);
    vecs[12] = mk(32'hFFFFFFFC, 1'b0, 4'hF, 32'h0,  1'b1, 32'h0);
    vecs[13] = mk(32'h20, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[14] = mk(32'h20, 1'b1, 4'b1100, 32'h12340000, 1'b0, 32'h0);
    vecs[15] = mk(32'h20, 1'b0, 4'hF, 32'h0,        1'b0, 32'h1234A5A5);

    bseq[0] = mk(32'h40, 1'b1, 4'hF, 32'h01020304, 1'b0, 32'h0);
    bseq[1] = mk(32'h40, 1'b0, 4'hF, 32'h0,        1'b0, 32'h01020304);
    bseq[2] = mk(32'h44, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    bseq[3] = mk(32'h40, 1'b0, 4'hF, 32'h0,        1'b0, 32'h01020304);

    // Reset: ready low during reset, high the first cycle after.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_rdy_in_reset", 32'(a_rdy), 32'd0);
    chk("b_rdy_in_reset", 32'(b_rdy), 32'd0);
    chk("a_vld_in_reset", 32'(a_rvld), 32'd0);
    @(posedge clk); #2;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("a_rdy_after_reset", 32'(a_rdy), 32'd1);
    chk("b_rdy_after_reset", 32'(b_rdy), 32'd1);

    for (int i = 0; i < 16; i++) begin
      send_a(vecs[i], 1'b1);
    end
    drain();

    // Reset on the last wait cycle of a write: no response, memory keeps its old word.
    send_a(mk(32'h20, 1'b1, 4'hF, 32'h12345678, 1'b0, 32'h0), 1'b0);
    @(posedge clk); #2;
    a_rst = 1'b1;
    @(negedge clk);
    chk("a_rdy_during_mid_reset", 32'(a_rdy), 32'd0);
    @(posedge clk); #2;
    a_rst = 1'b0;
    @(negedge clk);
    chk("a_rdy_after_mid_reset", 32'(a_rdy), 32'd1);
    send_a(mk(32'h20, 1'b0, 4'hF, 32'h0, 1'b0, 32'h1234A5A5), 1'b1);
    drain();

    // Zero wait states with valid held high across four requests.
    bi = 0;
    @(posedge clk); #2;
    b_vld = 1'b1; b_addr = bseq[0].addr; b_w_en = bseq[0].w_en; b_be = bseq[0].be; b_wdata = bseq[0].data;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_rdy_toggle", 32'(b_rdy), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (b_rdy && bi < 4) begin
        e.err = bseq[bi].err; e.data = bseq[bi].rdata; e.due = cyc + 1;
        qb.push_back(e);
        bi++;
      end
      @(posedge clk); #2;
      if (bi < 4) begin
        b_addr = bseq[bi].addr; b_w_en = bseq[bi].w_en; b_be = bseq[bi].be; b_wdata = bseq[bi].data;
      end else begin
        b_vld = 1'b0;
      end
    end
    chk("b_requests_accepted", 32'(bi), 32'd4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
